min_max_array_loader: RTL and testbench

- Producer-side companion to the min/max finder.
- Accepts a stream of unsigned 8-bit samples over a valid/ready handshake and writes them into a 16-entry array.
- When the array is full, pulses Start to the finder and holds the array stable until the finder reports done.
- Exposes a combinational read port so the finder reads M[I] from this block instead of owning the array.

---
 rtl/min_max_pkg.sv | 25 ++
 rtl/min_max_array_loader_if.sv | 32 +++
 rtl/min_max_regfile.sv | 27 ++
 rtl/min_max_array_loader.sv | 103 ++++++++++
 tb/tb_min_max_array_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/min_max_pkg.sv
// Shared constants and state encodings for the min/max loader and finder.
// Both blocks decode their one-hot state flags from these enums.
package min_max_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  // Loader states; bit order matches {Qw,Qk,Qf,Qi}
  typedef enum logic [3:0] {
    StIni  = 4'b0001,
    StFill = 4'b0010,
    StKick = 4'b0100,
    StWait = 4'b1000
  } loader_state_e;

  // Finder states; bit order matches {Qd,Qc,Ql,Qi}
  typedef enum logic [3:0] {
    FinIni  = 4'b0001,
    FinLoad = 4'b0010,
    FinComp = 4'b0100,
    FinDone = 4'b1000
  } finder_state_e;

endpackage

// File: rtl/min_max_array_loader_if.sv
// Loader-facing bundle: sample stream, finder handshake, read port and status flags.
// The master side drives samples and finder controls; the slave side is the loader.
interface min_max_array_loader_if;
  import min_max_pkg::*;

  logic             Go;
  logic             Abort;
  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic             StartOut;
  logic             FinderDone;
  logic [AW-1:0]    RdAddr;
  logic [WIDTH-1:0] RdData;
  logic [AW:0]      Count;
  logic             Full;
  logic             Qi;
  logic             Qf;
  logic             Qk;
  logic             Qw;

  modport master (
    output Go, Abort, InData, InValid, FinderDone, RdAddr,
    input  InReady, StartOut, RdData, Count, Full, Qi, Qf, Qk, Qw
  );

  modport slave (
    input  Go, Abort, InData, InValid, FinderDone, RdAddr,
    output InReady, StartOut, RdData, Count, Full, Qi, Qf, Qk, Qw
  );

endinterface

// File: rtl/min_max_regfile.sv
// Depth x Width array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module min_max_regfile #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic             Clk,
  input  logic             i_we,
  input  logic [Aw-1:0]    i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [Aw-1:0]    i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-edge value on a same-cycle write
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/min_max_array_loader.sv
// Fills a 16-entry array from a valid/ready stream, kicks the finder once full,
// and holds the array frozen until the finder reports done.
module min_max_array_loader
  import min_max_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  min_max_array_loader_if.slave  bus
);

  localparam logic [AW-1:0] LastPtr   = AW'(DEPTH - 1);
  localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);

  loader_state_e r_state, w_state_next;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [AW:0]   r_count, w_count_next;
  logic          w_we;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= StIni;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    w_we          = 1'b0;
    bus.InReady   = 1'b0;
    bus.StartOut  = 1'b0;
    unique case (r_state)
      StIni: begin
        if (bus.Go) begin
          w_state_next  = StFill;
          w_wr_ptr_next = '0;
          w_count_next  = '0;
        end
      end
      StFill: begin
        bus.InReady = 1'b1;
        // Abort beats a same-cycle transfer: nothing is written or counted
        if (bus.Abort) begin
          w_state_next  = StIni;
          w_wr_ptr_next = '0;
          w_count_next  = '0;
        end else if (bus.InValid) begin
          w_we          = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 1'b1;
          w_count_next  = r_count + 1'b1;
          if (r_wr_ptr == LastPtr) begin
            w_state_next = StKick;
          end
        end
      end
      StKick: begin
        bus.StartOut = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (bus.Abort) begin
          w_state_next  = StIni;
          w_wr_ptr_next = '0;
          w_count_next  = '0;
        end else if (bus.FinderDone) begin
          w_state_next = StIni;
        end
      end
      default: begin
        w_state_next  = StIni;
        w_wr_ptr_next = '0;
        w_count_next  = '0;
      end
    endcase
  end

  min_max_regfile #(
    .Width(WIDTH),
    .Depth(DEPTH),
    .Aw   (AW)
  ) u_regfile (
    .Clk    (Clk),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.InData),
    .i_raddr(bus.RdAddr),
    .o_rdata(bus.RdData)
  );

  assign bus.Count = r_count;
  assign bus.Full  = (r_count == CountFull);
  assign bus.Qi    = r_state[0];
  assign bus.Qf    = r_state[1];
  assign bus.Qk    = r_state[2];
  assign bus.Qw    = r_state[3];

endmodule

// File: tb/tb_min_max_array_loader.sv
// Bench for min_max_array_loader: model array + scoreboard queue of written samples,
// a gapped-stream vector table, and hand sequences for abort, wait and reset cases.
module tb_min_max_array_loader;
  import min_max_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  min_max_array_loader_if bus ();

  min_max_array_loader dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_kick;
  } gap_vec_t;

  gap_vec_t   gap_tbl [31];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_mem [16];
  logic [7:0] sb_q [$];
  int         exp_count;
  int         exp_ptr;
  bit         exp_fill;
  int         start_pulses = 0;
  logic [7:0] fmin, fmax, rd;
  bit         seen;

  always @(negedge Clk) if (bus.StartOut === 1'b1) start_pulses++;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic go_pulse();
    bus.Go = 1'b1;
    step();
    bus.Go    = 1'b0;
    exp_fill  = 1'b1;
    exp_count = 0;
    exp_ptr   = 0;
    sb_q.delete();
    check("go_qf", bus.Qf, 1);
    check("go_count", bus.Count, 0);
  endtask

  task automatic xfer(input logic valid, input logic [7:0] data);
    bus.InValid = valid;
    bus.InData  = data;
    #1;
    check("inready", bus.InReady, exp_fill);
    if (valid && exp_fill) begin
      exp_mem[exp_ptr] = data;
      sb_q.push_back(data);
      exp_ptr   = (exp_ptr + 1) % 16;
      exp_count = exp_count + 1;
      if (exp_count == 16) exp_fill = 1'b0;
    end
    step();
    bus.InValid = 1'b0;
    check("count", bus.Count, exp_count);
    check("full", bus.Full, exp_count == 16);
  endtask

  task automatic sb_drain();
    int n;
    logic [7:0] d;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      d = sb_q.pop_front();
      bus.RdAddr = 4'(i);
      #1;
      check("rd_sb", bus.RdData, d);
    end
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 16; i++) begin
      bus.RdAddr = 4'(i);
      #1;
      check(name, bus.RdData, exp_mem[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 31; i++) begin
      gap_tbl[i].valid     = (i % 2 == 0);
      gap_tbl[i].data      = ((i / 2) % 2 == 0) ? 8'hFF : 8'h00;
      gap_tbl[i].exp_count = 5'(i / 2 + 1);
      gap_tbl[i].exp_kick  = (i == 30);
    end
    bus.Go = 0; bus.Abort = 0; bus.InData = 0; bus.InValid = 0;
    bus.FinderDone = 0; bus.RdAddr = 0;
    exp_fill = 0; exp_count = 0; exp_ptr = 0;

    // Reset state
    Reset = 1'b1;
    #3;
    check("rst_qi", bus.Qi, 1);
    check("rst_qf", bus.Qf, 0);
    check("rst_inready", bus.InReady, 0);
    check("rst_start", bus.StartOut, 0);
    check("rst_count", bus.Count, 0);
    check("rst_full", bus.Full, 0);
    @(negedge Clk);
    Reset = 1'b0;
    step();

    // Back-to-back fill 10..1F
    start_pulses = 0;
    go_pulse();
    for (int i = 0; i < 16; i++) begin
      check("fill_nostart", bus.StartOut, 0);
      xfer(1'b1, 8'h10 + 8'(i));
    end
    check("kick_qk", bus.Qk, 1);
    check("kick_start", bus.StartOut, 1);
    check("kick_inready", bus.InReady, 0);
    step();
    check("wait_qw", bus.Qw, 1);
    check("wait_start", bus.StartOut, 0);
    sb_drain();

    // WAIT ignores the stream
    step();
    for (int i = 0; i < 10; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = 8'hAA;
      #1;
      check("wait_inready", bus.InReady, 0);
      step();
      check("wait_hold", bus.Qw, 1);
    end
    bus.InValid = 1'b0;
    check("start_once", start_pulses, 1);
    read_all("wait_frozen");
    step();
    bus.FinderDone = 1'b1;
    step();
    bus.FinderDone = 1'b0;
    check("done_qi", bus.Qi, 1);
    check("done_count_kept", bus.Count, 16);
    check("done_full_kept", bus.Full, 1);

    // Gapped stream from the vector table
    go_pulse();
    for (int i = 0; i < 31; i++) begin
      bus.InValid = gap_tbl[i].valid;
      bus.InData  = gap_tbl[i].data;
      #1;
      check("gap_inready", bus.InReady, 1);
      if (gap_tbl[i].valid) begin
        exp_mem[i / 2] = gap_tbl[i].data;
        sb_q.push_back(gap_tbl[i].data);
      end
      step();
      bus.InValid = 1'b0;
      check("gap_count", bus.Count, gap_tbl[i].exp_count);
      check("gap_kick", bus.Qk, gap_tbl[i].exp_kick);
    end
    check("gap_start", bus.StartOut, 1);
    step();
    sb_drain();
    step();
    bus.FinderDone = 1'b1;
    step();
    bus.FinderDone = 1'b0;
    check("gap_done_qi", bus.Qi, 1);

    // Finder hookup: 00 at index 7, FF at index 12
    go_pulse();
    for (int i = 0; i < 16; i++)
      xfer(1'b1, (i == 7) ? 8'h00 : (i == 12) ? 8'hFF : 8'h40 + 8'(i));
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (bus.StartOut === 1'b1) seen = 1'b1;
      else step();
    end
    check("finder_start_seen", seen, 1);
    step();
    fmin = 8'hFF;
    fmax = 8'h00;
    for (int i = 0; i < 16; i++) begin
      bus.RdAddr = 4'(i);
      #1;
      rd = bus.RdData;
      if (rd < fmin) fmin = rd;
      if (rd > fmax) fmax = rd;
      step();
    end
    check("finder_max", fmax, 8'hFF);
    check("finder_min", fmin, 8'h00);
    check("finder_wait", bus.Qw, 1);
    bus.FinderDone = 1'b1;
    step();
    bus.FinderDone = 1'b0;
    check("finder_done_qi", bus.Qi, 1);

    // Abort after 5 samples with a same-cycle transfer
    go_pulse();
    for (int i = 0; i < 5; i++) xfer(1'b1, 8'h50 + 8'(i));
    bus.Abort   = 1'b1;
    bus.InValid = 1'b1;
    bus.InData  = 8'hEE;
    step();
    bus.Abort   = 1'b0;
    bus.InValid = 1'b0;
    exp_fill = 1'b0; exp_count = 0; exp_ptr = 0;
    sb_q.delete();
    check("abort_qi", bus.Qi, 1);
    check("abort_count", bus.Count, 0);
    check("abort_inready", bus.InReady, 0);
    bus.RdAddr = 4'd5;
    #1;
    check("abort_m5", bus.RdData, 8'h45);
    step();

    // Refill from M[0]; Abort in KICK ignored; Abort+FinderDone in WAIT
    go_pulse();
    for (int i = 0; i < 16; i++) xfer(1'b1, 8'h60 + 8'(i));
    bus.Abort = 1'b1;
    #1;
    check("kick_abort_start", bus.StartOut, 1);
    step();
    bus.Abort = 1'b0;
    check("kick_abort_qw", bus.Qw, 1);
    sb_drain();
    step();
    bus.Abort      = 1'b1;
    bus.FinderDone = 1'b1;
    step();
    bus.Abort      = 1'b0;
    bus.FinderDone = 1'b0;
    check("wait_abort_qi", bus.Qi, 1);
    check("wait_abort_count", bus.Count, 0);

    // Async reset mid-FILL
    go_pulse();
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'h70 + 8'(i));
    #3;
    Reset = 1'b1;
    #1;
    check("arst_qi", bus.Qi, 1);
    check("arst_qf", bus.Qf, 0);
    check("arst_inready", bus.InReady, 0);
    check("arst_count", bus.Count, 0);
    #2;
    Reset = 1'b0;
    exp_fill = 1'b0; exp_count = 0; exp_ptr = 0;
    go_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
